// File: rtl/dmac_scheduler.sv
// dmac_scheduler: multi-channel DMA burst scheduler.
// Holds one descriptor per channel, splits each transfer into AXI INCR
// bursts that stay inside a 4 KB page, and hands bursts one at a time to
// the shared read/write engines with round-robin arbitration per burst.
//
// Handshake semantics: ch_req_i is a level request whose descriptor fields
// must stay valid while high; ch_ack_o pulses in the cycle the descriptor is
// captured (combinational, so the host drops ch_req_i after that edge).
// rd_valid_o/wr_valid_o are one-cycle start pulses; the engines answer with
// one-cycle rd_done_i/wr_done_i pulses in any order, possibly together.
module dmac_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_BITS   = 8,
  parameter int SIZE_BITS  = 3,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_BURST  = 16,
  parameter int GW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            ch_req_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_src_addr_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_dst_addr_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]  ch_beats_i,
  output logic [NUM_CH-1:0]            ch_ack_o,
  output logic [NUM_CH-1:0]            ch_done_o,
  output logic [NUM_CH-1:0]            ch_err_o,
  output logic                         rd_valid_o,
  output logic [ADDR_WIDTH-1:0]        rd_src_addr_o,
  output logic                         wr_valid_o,
  output logic [ADDR_WIDTH-1:0]        wr_dst_addr_o,
  output logic [LEN_BITS-1:0]          eng_len_o,
  output logic [SIZE_BITS-1:0]         eng_size_o,
  output logic [1:0]                   eng_burst_o,
  input  logic                         rd_done_i,
  input  logic                         wr_done_i,
  input  logic [1:0]                   wr_bresp_i,
  output logic                         busy_o,
  output logic [GW-1:0]                grant_o,
  output logic [2:0]                   state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;

  logic [2:0]            state, state_nxt;
  logic [NUM_CH-1:0]     active;
  logic [ADDR_WIDTH-1:0] src [NUM_CH];
  logic [ADDR_WIDTH-1:0] dst [NUM_CH];
  logic [CNT_WIDTH-1:0]  rem [NUM_CH];
  logic [GW-1:0]         last_grant, grant_q;
  logic [LEN_BITS:0]     beats_q;
  logic [LEN_BITS-1:0]   len_q;
  logic [ADDR_WIDTH-1:0] rd_src_q, wr_dst_q;
  logic                  rd_seen, wr_seen;
  logic [1:0]            bresp_q;

  // Descriptor capture candidate
  logic                  cap_valid;
  logic [GW-1:0]         cap_idx;
  logic [CNT_WIDTH-1:0]  cap_beats;
  logic [ADDR_WIDTH-1:0] cap_src, cap_dst;
  logic [NUM_CH-1:0]     cap_oh;
  logic                  cap_zero;

  // Arbitration result
  logic                  hi_found, lo_found, arb_found;
  logic [GW-1:0]         hi_idx, lo_idx, arb_idx;
  logic [ADDR_WIDTH-1:0] g_src, g_dst;
  logic [CNT_WIDTH-1:0]  g_rem;
  logic [12:0]           src_room, dst_room;
  logic [31:0]           beats_min;
  logic [LEN_BITS:0]     beats_nxt;

  logic [NUM_CH-1:0]     grant_oh;
  logic                  upd_last;

  // Pick the lowest-index idle channel that is requesting (only in IDLE/ARB)
  always_comb begin
    cap_valid = 1'b0;
    cap_idx   = '0;
    cap_beats = '0;
    cap_src   = '0;
    cap_dst   = '0;
    if (!rst_i && (state == S_IDLE || state == S_ARB)) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (ch_req_i[i] && !active[i]) begin
          cap_valid = 1'b1;
          cap_idx   = GW'(i);
          cap_beats = ch_beats_i[i*CNT_WIDTH +: CNT_WIDTH];
          cap_src   = ch_src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
          cap_dst   = ch_dst_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
    end
    cap_zero = (cap_beats == '0);
    for (int i = 0; i < NUM_CH; i++) begin
      cap_oh[i] = cap_valid && (cap_idx == GW'(i));
    end
  end

  // Round-robin: first active channel above last_grant, else lowest active
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (active[i]) begin
        lo_found = 1'b1;
        lo_idx   = GW'(i);
        if (GW'(i) > last_grant) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
        end
      end
    end
    arb_found = hi_found || lo_found;
    arb_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Burst length: limited by remaining beats, MAX_BURST and both 4 KB pages
  always_comb begin
    g_src     = src[arb_idx];
    g_dst     = dst[arb_idx];
    g_rem     = rem[arb_idx];
    src_room  = (13'h1000 - {1'b0, g_src[11:0]}) >> 2;
    dst_room  = (13'h1000 - {1'b0, g_dst[11:0]}) >> 2;
    beats_min = 32'(MAX_BURST);
    if (32'(g_rem) < beats_min)    beats_min = 32'(g_rem);
    if (32'(src_room) < beats_min) beats_min = 32'(src_room);
    if (32'(dst_room) < beats_min) beats_min = 32'(dst_room);
    beats_nxt = beats_min[LEN_BITS:0];
  end

  // Decode of the owning channel and last-burst detection for UPDATE
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      grant_oh[i] = (grant_q == GW'(i));
    end
    upd_last = (rem[grant_q] == CNT_WIDTH'(beats_q));
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if ((|active) || (cap_valid && !cap_zero)) state_nxt = S_ARB;
      S_ARB:    state_nxt = arb_found ? S_ISSUE : S_IDLE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   if ((rd_seen || rd_done_i) && (wr_seen || wr_done_i)) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_ARB;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State, channel contexts and per-burst registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      active     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        src[i] <= '0;
        dst[i] <= '0;
        rem[i] <= '0;
      end
      last_grant <= GW'(NUM_CH - 1);
      grant_q    <= '0;
      beats_q    <= '0;
      len_q      <= '0;
      rd_src_q   <= '0;
      wr_dst_q   <= '0;
      rd_seen    <= 1'b0;
      wr_seen    <= 1'b0;
      bresp_q    <= 2'b00;
    end else begin
      state <= state_nxt;
      if (cap_valid && !cap_zero) begin
        active[cap_idx] <= 1'b1;
        src[cap_idx]    <= cap_src & ~ADDR_WIDTH'(3);
        dst[cap_idx]    <= cap_dst & ~ADDR_WIDTH'(3);
        rem[cap_idx]    <= cap_beats;
      end
      case (state)
        S_ARB: begin
          if (arb_found) begin
            grant_q    <= arb_idx;
            last_grant <= arb_idx;
            beats_q    <= beats_nxt;
            len_q      <= LEN_BITS'(beats_nxt - 1'b1);
            rd_src_q   <= g_src;
            wr_dst_q   <= g_dst;
            rd_seen    <= 1'b0;
            wr_seen    <= 1'b0;
            bresp_q    <= 2'b00;
          end
        end
        S_WAIT: begin
          if (rd_done_i) rd_seen <= 1'b1;
          if (wr_done_i) begin
            wr_seen <= 1'b1;
            bresp_q <= wr_bresp_i;
          end
        end
        S_UPDATE: begin
          if (bresp_q != 2'b00) begin
            active[grant_q] <= 1'b0;
          end else begin
            src[grant_q] <= src[grant_q] + ADDR_WIDTH'({beats_q, 2'b00});
            dst[grant_q] <= dst[grant_q] + ADDR_WIDTH'({beats_q, 2'b00});
            rem[grant_q] <= rem[grant_q] - CNT_WIDTH'(beats_q);
            if (upd_last) active[grant_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    ch_ack_o      = cap_oh;
    ch_done_o     = (cap_valid && cap_zero) ? cap_oh : '0;
    ch_err_o      = '0;
    if (!rst_i && state == S_UPDATE) begin
      if (bresp_q != 2'b00) ch_err_o = grant_oh;
      else if (upd_last)    ch_done_o = ch_done_o | grant_oh;
    end
    rd_valid_o    = (state == S_ISSUE);
    wr_valid_o    = (state == S_ISSUE);
    rd_src_addr_o = rd_src_q;
    wr_dst_addr_o = wr_dst_q;
    eng_len_o     = len_q;
    eng_size_o    = SIZE_BITS'(2);
    eng_burst_o   = 2'b01;
    busy_o        = (|active) || (state != S_IDLE);
    grant_o       = grant_q;
    state_o       = state;
  end

endmodule
